// File: rtl/dm_param.sv
// Parametrised SORT data memory: a synchronous init sequencer preloads the dataset, then the memory serves word reads and writes.
// Optional registered read port, enabled by defining DM_SYNC_READ_EN.
module dm_param #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  busy,
  output logic                  err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]         LAST    = CW'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {INIT, RUN} state_t;

  state_t                state, state_nx;
  logic [CW-1:0]         cnt, cnt_nx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  in_range;
  logic [IW-1:0]         idx, cidx;

  // SORT dataset; entries past index 9 load zero
  function automatic logic [DATA_WIDTH-1:0] preload(input logic [CW-1:0] i);
    logic [15:0]            v;
    logic [DATA_WIDTH+15:0] ext;
    case (int'(i))
      0:       v = 16'h0127;
      1:       v = 16'h0559;
      2:       v = 16'h0059;
      3:       v = 16'h0059;
      4:       v = 16'h0102;
      5:       v = 16'h0048;
      6:       v = 16'h0000;
      7:       v = 16'h0100;
      8:       v = 16'h10C3;
      9:       v = 16'h00CD;
      default: v = 16'h0000;
    endcase
    ext = {{DATA_WIDTH{1'b0}}, v};
    return ext[DATA_WIDTH-1:0];
  endfunction

  assign busy     = (state == INIT);
  assign in_range = ({1'b0, addr} < DEPTH_W);
  assign idx      = addr[IW-1:0];
  assign cidx     = cnt[IW-1:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (state == INIT) begin
      cnt_nx = cnt + CW'(1);
      if (cnt == LAST) state_nx = RUN;
    end
  end

  // Contents survive reset; INIT rewrites every word
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == INIT)        mem[cidx] <= preload(cnt);
      else if (we && in_range)  mem[idx]  <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) err <= 1'b0;
    else        err <= we && (busy || !in_range);
  end

`ifdef DM_SYNC_READ_EN
  // Write-first: a same-cycle write is forwarded into the read register
  always_ff @(posedge clk) begin
    if (!reset || busy || !in_range) dout <= '0;
    else if (we)                     dout <= din;
    else                             dout <= mem[idx];
  end
`else
  always_comb dout = (!busy && in_range) ? mem[idx] : '0;
`endif

endmodule

// File: tb/tb_dm_param.sv
// Bench for dm_param: a default instance (10x16) and a 16x32 instance checked every cycle
// against a behavioural model, plus directed reads with literal expectations.
module tb_dm_param;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  addr_v [2];
  logic [31:0] din_v  [2];
  logic        we_v   [2];
  logic [15:0] dout0;
  logic [31:0] dout1;
  logic        busy0, busy1, err0, err1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dm_param u_dut0 (
    .clk(clk), .reset(reset), .addr(addr_v[0]), .din(din_v[0][15:0]), .we(we_v[0]),
    .dout(dout0), .busy(busy0), .err(err0)
  );

  dm_param #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(16)) u_dut1 (
    .clk(clk), .reset(reset), .addr(addr_v[1]), .din(din_v[1]), .we(we_v[1]),
    .dout(dout1), .busy(busy1), .err(err1)
  );

  // ---------------- behavioural model ----------------
  logic [15:0] tbl [10] = '{16'h0127, 16'h0559, 16'h0059, 16'h0059, 16'h0102,
                            16'h0048, 16'h0000, 16'h0100, 16'h10C3, 16'h00CD};
  int          dep [2] = '{10, 16};
  logic [31:0] msk [2] = '{32'h0000FFFF, 32'hFFFFFFFF};
  logic [31:0] mm  [2][16];
  int          left [2];
  logic        e_err [2];
  logic [31:0] s_dout [2];
  logic        known = 1'b0;

  function automatic logic [31:0] tval(int i);
    return (i < 10) ? {16'h0, tbl[i]} : 32'h0;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        left[k] = dep[k]; e_err[k] = 1'b0; s_dout[k] = '0; known = 1'b1;
      end else begin
        automatic bit was_busy = (left[k] > 0);
        automatic bit oor = (int'(addr_v[k]) >= dep[k]);
        e_err[k] = we_v[k] && (was_busy || oor);
        if (was_busy) begin
          mm[k][dep[k] - left[k]] = tval(dep[k] - left[k]) & msk[k];
          left[k] = left[k] - 1;
        end else if (we_v[k] && !oor) begin
          mm[k][addr_v[k]] = din_v[k] & msk[k];
        end
        s_dout[k] = (was_busy || oor) ? 32'h0 : mm[k][addr_v[k]];
      end
    end
  end

  function automatic logic [31:0] exp_dout(int k);
`ifdef DM_SYNC_READ_EN
    return s_dout[k];
`else
    if (left[k] > 0 || int'(addr_v[k]) >= dep[k]) return 32'h0;
    return mm[k][addr_v[k]];
`endif
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (known) begin
      chk("m_busy0", {31'h0, busy0}, {31'h0, left[0] > 0});
      chk("m_err0",  {31'h0, err0},  {31'h0, e_err[0]});
      chk("m_dout0", {16'h0, dout0}, exp_dout(0));
      chk("m_busy1", {31'h0, busy1}, {31'h0, left[1] > 0});
      chk("m_err1",  {31'h0, err1},  {31'h0, e_err[1]});
      chk("m_dout1", dout1,          exp_dout(1));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic rd(int k, logic [7:0] a, logic [31:0] exp, string nm);
    addr_v[k] = a;
`ifdef DM_SYNC_READ_EN
    @(posedge clk);
`endif
    @(negedge clk);
    chk(nm, (k == 0) ? {16'h0, dout0} : dout1, exp);
    step();
  endtask

  task automatic wr(int k, logic [7:0] a, logic [31:0] d);
    we_v[k] = 1'b1; addr_v[k] = a; din_v[k] = d;
    step();
    we_v[k] = 1'b0;
  endtask

  task automatic wait_init(output int n0, output int n1);
    int n = 0;
    n0 = 0;
    do begin
      step(); n++;
      if (!busy0 && n0 == 0) n0 = n;
    end while ((busy0 || busy1) && n < 40);
    n1 = n;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, n0, n1;
    logic [31:0] pre [10] = '{32'h0127, 32'h0559, 32'h0059, 32'h0059, 32'h0102,
                              32'h0048, 32'h0000, 32'h0100, 32'h10C3, 32'h00CD};
    for (int k = 0; k < 2; k++) begin
      addr_v[k] = '0; din_v[k] = '0; we_v[k] = 1'b0;
    end

    step();
    chk("rst_busy", {31'h0, busy0}, 32'h1);
    chk("rst_err",  {31'h0, err0},  32'h0);
    chk("rst_dout", {16'h0, dout0}, 32'h0);
    reset = 1'b1;

    // INIT with a rejected write on the 3rd INIT cycle
    n = 0; n0 = 0;
    do begin
      if (n == 2) begin we_v[0] = 1'b1; addr_v[0] = 8'd1; din_v[0] = 32'hFFFF; end
      step(); n++;
      we_v[0] = 1'b0;
      if (n == 3) chk("init_wr_err", {31'h0, err0}, 32'h1);
      if (n == 4) chk("init_err_end", {31'h0, err0}, 32'h0);
      if (!busy0 && n0 == 0) n0 = n;
    end while ((busy0 || busy1) && n < 40);
    chk("init_len0", n0, 10);
    chk("init_len1", n, 16);
    chk("model_pin", mm[0][1], 32'h0559);

    for (int i = 0; i < 10; i++) rd(0, 8'(i), pre[i], "preload");

    wr(0, 8'd3, 32'hBEEF);
    chk("wr_err", {31'h0, err0}, 32'h0);
    rd(0, 8'd3, 32'hBEEF, "wr_back");
    rd(0, 8'd2, 32'h0059, "wr_neighbour");

    wr(0, 8'd9, 32'h0909);
    chk("wr_last_err", {31'h0, err0}, 32'h0);
    rd(0, 8'd9, 32'h0909, "wr_last_back");

    // out-of-range, single then back-to-back
    wr(0, 8'h0C, 32'h1234);
    chk("oor_err", {31'h0, err0}, 32'h1);
    step();
    chk("oor_err_end", {31'h0, err0}, 32'h0);
    rd(0, 8'h0C, 32'h0, "oor_read");
    we_v[0] = 1'b1; addr_v[0] = 8'h0A; din_v[0] = 32'h1111;
    step();
    chk("b2b_err1", {31'h0, err0}, 32'h1);
    addr_v[0] = 8'hFF;
    step();
    we_v[0] = 1'b0;
    chk("b2b_err2", {31'h0, err0}, 32'h1);
    step();
    chk("b2b_err_end", {31'h0, err0}, 32'h0);

    // read during write
    we_v[0] = 1'b1; addr_v[0] = 8'd5; din_v[0] = 32'h5555;
`ifndef DM_SYNC_READ_EN
    @(negedge clk);
    chk("rdw_old", {16'h0, dout0}, 32'h0048);
`endif
    step();
    we_v[0] = 1'b0;
`ifdef DM_SYNC_READ_EN
    @(negedge clk);
    chk("rdw_new", {16'h0, dout0}, 32'h5555);
    step();
`endif
    rd(0, 8'd5, 32'h5555, "rdw_after");

    // 32-bit, DEPTH=16 instance
    rd(1, 8'd9,  32'h000000CD, "w32_a9");
    rd(1, 8'd12, 32'h00000000, "w32_a12");
    rd(1, 8'd8,  32'h000010C3, "w32_a8");
    wr(1, 8'd15, 32'hDEADBEEF);
    chk("w32_err15", {31'h0, err1}, 32'h0);
    rd(1, 8'd15, 32'hDEADBEEF, "w32_a15");
    wr(1, 8'd16, 32'h12345678);
    chk("w32_err16", {31'h0, err1}, 32'h1);
    rd(1, 8'd16, 32'h0, "w32_a16");

    // reset mid-RUN
    wr(0, 8'd0, 32'hAAAA);
    rd(0, 8'd0, 32'hAAAA, "mid_wr");
    reset = 1'b0; we_v[0] = 1'b1; addr_v[0] = 8'd0; din_v[0] = 32'h7777;
    step();
    reset = 1'b1; we_v[0] = 1'b0;
    chk("mid_rst_err", {31'h0, err0}, 32'h0);
    wait_init(n0, n1);
    chk("mid_len0", n0, 10);
    rd(0, 8'd0, 32'h0127, "mid_reload");

    // reset mid-INIT
    reset = 1'b0; step(); reset = 1'b1;
    repeat (4) step();
    chk("minit_busy", {31'h0, busy0}, 32'h1);
    reset = 1'b0; step(); reset = 1'b1;
    wait_init(n0, n1);
    chk("minit_len0", n0, 10);
    chk("minit_len1", n1, 16);
    rd(0, 8'd8, 32'h10C3, "minit_a8");
    rd(1, 8'd15, 32'h0, "minit_w32_a15");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
